// File: rtl/vx_mem_port_perf_mon.sv
// Per-port memory-interface performance monitor: snoops request/response handshakes and keeps
// read/write/latency counters per port and in aggregate, plus outstanding-read tracking.
module vx_mem_port_perf_mon #(
    parameter int NUM_PORTS = 1,
    parameter int CTR_BITS  = 44,
    parameter int PEND_BITS = 16,
    parameter int SATURATE  = 1
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          enable,
    input  logic                                          clear,
    input  logic [NUM_PORTS-1:0]                          req_valid,
    input  logic [NUM_PORTS-1:0]                          req_ready,
    input  logic [NUM_PORTS-1:0]                          req_rw,
    input  logic [NUM_PORTS-1:0]                          rsp_valid,
    input  logic [NUM_PORTS-1:0]                          rsp_ready,
    output logic [NUM_PORTS*CTR_BITS-1:0]                 port_reads,
    output logic [NUM_PORTS*CTR_BITS-1:0]                 port_writes,
    output logic [NUM_PORTS*CTR_BITS-1:0]                 port_latency,
    output logic [NUM_PORTS*PEND_BITS-1:0]                port_pending,
    output logic [CTR_BITS-1:0]                           total_reads,
    output logic [CTR_BITS-1:0]                           total_writes,
    output logic [CTR_BITS-1:0]                           total_latency,
    output logic [PEND_BITS+$clog2(NUM_PORTS+1)-1:0]      peak_pending,
    output logic [NUM_PORTS-1:0]                          underflow_err
);

    localparam int CNT_W = $clog2(NUM_PORTS + 1);
    localparam int PK_W  = PEND_BITS + CNT_W;
    localparam int ACC_W = ((CTR_BITS > PK_W) ? CTR_BITS : PK_W) + 1;

    logic [NUM_PORTS-1:0] rd_fire, wr_fire, rsp_fire;

    logic [PEND_BITS-1:0] pend_q   [NUM_PORTS];
    logic [PEND_BITS-1:0] pend_d   [NUM_PORTS];
    logic [CTR_BITS-1:0]  reads_q  [NUM_PORTS];
    logic [CTR_BITS-1:0]  reads_d  [NUM_PORTS];
    logic [CTR_BITS-1:0]  writes_q [NUM_PORTS];
    logic [CTR_BITS-1:0]  writes_d [NUM_PORTS];
    logic [CTR_BITS-1:0]  lat_q    [NUM_PORTS];
    logic [CTR_BITS-1:0]  lat_d    [NUM_PORTS];
    logic [NUM_PORTS-1:0] uflow_q, uflow_d;
    logic [CTR_BITS-1:0]  tot_rd_q, tot_rd_d;
    logic [CTR_BITS-1:0]  tot_wr_q, tot_wr_d;
    logic [CTR_BITS-1:0]  tot_lat_q, tot_lat_d;
    logic [PK_W-1:0]      peak_q, peak_d;
    logic [CNT_W-1:0]     rd_cnt, wr_cnt;
    logic [PK_W-1:0]      lat_sum, pend_sum;

    assign rd_fire  = req_valid & req_ready & ~req_rw;
    assign wr_fire  = req_valid & req_ready & req_rw;
    assign rsp_fire = rsp_valid & rsp_ready;

    // The increment may be wider than the counter, so overflow is judged in a wider sum.
    function automatic logic [CTR_BITS-1:0] ctr_add(input logic [CTR_BITS-1:0] a,
                                                    input logic [ACC_W-1:0]    inc);
        logic [ACC_W-1:0] s;
        s = ACC_W'(a) + inc;
        if ((SATURATE != 0) && (s[ACC_W-1:CTR_BITS] != '0)) return '1;
        return s[CTR_BITS-1:0];
    endfunction

    always_comb begin
        uflow_d = uflow_q;
        for (int i = 0; i < NUM_PORTS; i++) begin
            pend_d[i] = pend_q[i];
            if (rd_fire[i] && !rsp_fire[i]) begin
                if (pend_q[i] != '1) pend_d[i] = pend_q[i] + PEND_BITS'(1);
            end else if (!rd_fire[i] && rsp_fire[i]) begin
                if (pend_q[i] == '0) uflow_d[i] = 1'b1;
                else                 pend_d[i] = pend_q[i] - PEND_BITS'(1);
            end
        end
    end

    always_comb begin
        rd_cnt   = '0;
        wr_cnt   = '0;
        lat_sum  = '0;
        pend_sum = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            rd_cnt   = rd_cnt + CNT_W'(rd_fire[i]);
            wr_cnt   = wr_cnt + CNT_W'(wr_fire[i]);
            lat_sum  = lat_sum + PK_W'(pend_q[i]);
            pend_sum = pend_sum + PK_W'(pend_d[i]);
        end
    end

    // Latency accumulates the outstanding count held before this cycle's update.
    always_comb begin
        tot_rd_d  = tot_rd_q;
        tot_wr_d  = tot_wr_q;
        tot_lat_d = tot_lat_q;
        peak_d    = peak_q;
        for (int i = 0; i < NUM_PORTS; i++) begin
            reads_d[i]  = reads_q[i];
            writes_d[i] = writes_q[i];
            lat_d[i]    = lat_q[i];
        end
        if (clear) begin
            tot_rd_d  = '0;
            tot_wr_d  = '0;
            tot_lat_d = '0;
            peak_d    = '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                reads_d[i]  = '0;
                writes_d[i] = '0;
                lat_d[i]    = '0;
            end
        end else if (enable) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                reads_d[i]  = ctr_add(reads_q[i], ACC_W'(rd_fire[i]));
                writes_d[i] = ctr_add(writes_q[i], ACC_W'(wr_fire[i]));
                lat_d[i]    = ctr_add(lat_q[i], ACC_W'(pend_q[i]));
            end
            tot_rd_d  = ctr_add(tot_rd_q, ACC_W'(rd_cnt));
            tot_wr_d  = ctr_add(tot_wr_q, ACC_W'(wr_cnt));
            tot_lat_d = ctr_add(tot_lat_q, ACC_W'(lat_sum));
            peak_d    = (pend_sum > peak_q) ? pend_sum : peak_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            uflow_q   <= '0;
            tot_rd_q  <= '0;
            tot_wr_q  <= '0;
            tot_lat_q <= '0;
            peak_q    <= '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                pend_q[i]   <= '0;
                reads_q[i]  <= '0;
                writes_q[i] <= '0;
                lat_q[i]    <= '0;
            end
        end else begin
            uflow_q   <= uflow_d;
            tot_rd_q  <= tot_rd_d;
            tot_wr_q  <= tot_wr_d;
            tot_lat_q <= tot_lat_d;
            peak_q    <= peak_d;
            for (int i = 0; i < NUM_PORTS; i++) begin
                pend_q[i]   <= pend_d[i];
                reads_q[i]  <= reads_d[i];
                writes_q[i] <= writes_d[i];
                lat_q[i]    <= lat_d[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_flat
        assign port_reads[g*CTR_BITS +: CTR_BITS]     = reads_q[g];
        assign port_writes[g*CTR_BITS +: CTR_BITS]    = writes_q[g];
        assign port_latency[g*CTR_BITS +: CTR_BITS]   = lat_q[g];
        assign port_pending[g*PEND_BITS +: PEND_BITS] = pend_q[g];
    end

    assign total_reads   = tot_rd_q;
    assign total_writes  = tot_wr_q;
    assign total_latency = tot_lat_q;
    assign peak_pending  = peak_q;
    assign underflow_err = uflow_q;

endmodule

// File: tb/tb_vx_mem_port_perf_mon.sv
// Directed bench: one saturating and one wrapping monitor share the same stimulus; expected
// values are queued per step and drained against the registered outputs after the clock.
module tb_vx_mem_port_perf_mon;

    localparam int NP  = 4;
    localparam int CW  = 4;
    localparam int PB  = 4;
    localparam int PKW = PB + $clog2(NP + 1);

    localparam int SEL_RD = 0, SEL_WR = 1, SEL_LAT = 2, SEL_PEND = 3, SEL_TRD = 4;
    localparam int SEL_TWR = 5, SEL_TLAT = 6, SEL_PEAK = 7, SEL_UF = 8;

    logic          clk = 1'b0;
    logic          reset, enable, clear;
    logic [NP-1:0] req_valid, req_ready, req_rw, rsp_valid, rsp_ready;

    logic [NP*CW-1:0] s_reads, s_writes, s_lat, w_reads, w_writes, w_lat;
    logic [NP*PB-1:0] s_pend, w_pend;
    logic [CW-1:0]    s_trd, s_twr, s_tlat, w_trd, w_twr, w_tlat;
    logic [PKW-1:0]   s_peak, w_peak;
    logic [NP-1:0]    s_uf, w_uf;

    typedef struct {
        string  tag;
        int     dut;
        int     sel;
        int     port;
        longint exp;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    vx_mem_port_perf_mon #(.NUM_PORTS(NP), .CTR_BITS(CW), .PEND_BITS(PB), .SATURATE(1)) dut_sat (
        .clk(clk), .reset(reset), .enable(enable), .clear(clear),
        .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .port_reads(s_reads), .port_writes(s_writes), .port_latency(s_lat), .port_pending(s_pend),
        .total_reads(s_trd), .total_writes(s_twr), .total_latency(s_tlat),
        .peak_pending(s_peak), .underflow_err(s_uf)
    );

    vx_mem_port_perf_mon #(.NUM_PORTS(NP), .CTR_BITS(CW), .PEND_BITS(PB), .SATURATE(0)) dut_wrap (
        .clk(clk), .reset(reset), .enable(enable), .clear(clear),
        .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .port_reads(w_reads), .port_writes(w_writes), .port_latency(w_lat), .port_pending(w_pend),
        .total_reads(w_trd), .total_writes(w_twr), .total_latency(w_tlat),
        .peak_pending(w_peak), .underflow_err(w_uf)
    );

    function automatic longint getObserved(input int dut, input int sel, input int port);
        logic w;
        w = (dut != 0);
        case (sel)
            SEL_RD:   return longint'(w ? w_reads[port*CW +: CW]  : s_reads[port*CW +: CW]);
            SEL_WR:   return longint'(w ? w_writes[port*CW +: CW] : s_writes[port*CW +: CW]);
            SEL_LAT:  return longint'(w ? w_lat[port*CW +: CW]    : s_lat[port*CW +: CW]);
            SEL_PEND: return longint'(w ? w_pend[port*PB +: PB]   : s_pend[port*PB +: PB]);
            SEL_TRD:  return longint'(w ? w_trd  : s_trd);
            SEL_TWR:  return longint'(w ? w_twr  : s_twr);
            SEL_TLAT: return longint'(w ? w_tlat : s_tlat);
            SEL_PEAK: return longint'(w ? w_peak : s_peak);
            default:  return longint'(w ? w_uf   : s_uf);
        endcase
    endfunction

    task automatic pushExpect(input string tag, input int dut, input int sel, input int port,
                              input longint exp);
        exp_t e;
        e.tag  = tag;
        e.dut  = dut;
        e.sel  = sel;
        e.port = port;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    task automatic pushBoth(input string tag, input int sel, input int port, input longint exp);
        pushExpect(tag, 0, sel, port, exp);
        pushExpect(tag, 1, sel, port, exp);
    endtask

    task automatic pushAllZero(input string tag);
        for (int p = 0; p < NP; p++) begin
            pushBoth({tag, "_reads"}, SEL_RD, p, 0);
            pushBoth({tag, "_writes"}, SEL_WR, p, 0);
            pushBoth({tag, "_lat"}, SEL_LAT, p, 0);
            pushBoth({tag, "_pend"}, SEL_PEND, p, 0);
        end
        pushBoth({tag, "_trd"}, SEL_TRD, 0, 0);
        pushBoth({tag, "_twr"}, SEL_TWR, 0, 0);
        pushBoth({tag, "_tlat"}, SEL_TLAT, 0, 0);
        pushBoth({tag, "_peak"}, SEL_PEAK, 0, 0);
        pushBoth({tag, "_uf"}, SEL_UF, 0, 0);
    endtask

    task automatic checkOutput();
        exp_t   e;
        longint obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = getObserved(e.dut, e.sel, e.port);
            checks++;
            assert (obs === e.exp) else begin
                errors++;
                $error("[TB] FAIL %s dut=%s port=%0d observed %0d expected %0d",
                       e.tag, (e.dut != 0) ? "wrap" : "sat", e.port, obs, e.exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [NP-1:0] rd, input logic [NP-1:0] wr,
                                 input logic [NP-1:0] rsp);
        req_valid = rd | wr;
        req_ready = rd | wr;
        req_rw    = wr;
        rsp_valid = rsp;
        rsp_ready = rsp;
        tick();
    endtask

    task automatic doClear();
        clear = 1'b1;
        applyStimulus('0, '0, '0);
        clear = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        enable = 1'b1;
        clear = 1'b0;
        applyStimulus('0, '0, '0);
        applyStimulus('0, '0, '0);
        reset = 1'b0;

        // Traffic, then a single reset cycle with traffic still present
        applyStimulus(4'b0011, '0, '0);
        applyStimulus(4'b0011, 4'b0100, 4'b0001);
        reset = 1'b1;
        applyStimulus(4'b1111, '0, 4'b0010);
        reset = 1'b0;
        pushAllZero("reset");
        checkOutput();

        // Single port: reads on cycles 0..2, responses on cycles 5..7
        for (int c = 0; c < 3; c++) applyStimulus(4'b0001, '0, '0);
        pushBoth("a_pend3", SEL_PEND, 0, 3);
        pushBoth("a_lat_mid", SEL_LAT, 0, 3);
        checkOutput();
        applyStimulus('0, '0, '0);
        applyStimulus('0, '0, '0);
        for (int c = 0; c < 3; c++) applyStimulus('0, '0, 4'b0001);
        pushBoth("a_reads", SEL_RD, 0, 3);
        pushBoth("a_pend0", SEL_PEND, 0, 0);
        pushBoth("a_lat", SEL_LAT, 0, 15);
        pushBoth("a_tlat", SEL_TLAT, 0, 15);
        pushBoth("a_trd", SEL_TRD, 0, 3);
        pushBoth("a_peak", SEL_PEAK, 0, 3);
        checkOutput();

        // Clear coinciding with a read: counters zero, pending still advances
        clear = 1'b1;
        applyStimulus(4'b0001, '0, '0);
        clear = 1'b0;
        pushBoth("clr_reads", SEL_RD, 0, 0);
        pushBoth("clr_trd", SEL_TRD, 0, 0);
        pushBoth("clr_lat", SEL_LAT, 0, 0);
        pushBoth("clr_peak", SEL_PEAK, 0, 0);
        pushBoth("clr_pend", SEL_PEND, 0, 1);
        checkOutput();
        applyStimulus('0, '0, 4'b0001);
        pushBoth("clr_resume_lat", SEL_LAT, 0, 1);
        pushBoth("clr_resume_pend", SEL_PEND, 0, 0);
        pushBoth("clr_resume_peak", SEL_PEAK, 0, 0);
        checkOutput();
        doClear();

        // All four ports in one cycle, port 2 writing
        applyStimulus(4'b1011, 4'b0100, '0);
        pushBoth("b_trd", SEL_TRD, 0, 3);
        pushBoth("b_twr", SEL_TWR, 0, 1);
        pushBoth("b_wr2", SEL_WR, 2, 1);
        pushBoth("b_rd2", SEL_RD, 2, 0);
        pushBoth("b_rd3", SEL_RD, 3, 1);
        pushBoth("b_pend2", SEL_PEND, 2, 0);
        pushBoth("b_pend3", SEL_PEND, 3, 1);
        pushBoth("b_peak", SEL_PEAK, 0, 3);
        checkOutput();
        applyStimulus('0, '0, 4'b1011);
        pushBoth("b_tlat", SEL_TLAT, 0, 3);
        pushBoth("b_lat1", SEL_LAT, 1, 1);
        pushBoth("b_pend1", SEL_PEND, 1, 0);
        pushBoth("b_peak_hold", SEL_PEAK, 0, 3);
        checkOutput();
        doClear();

        // Simultaneous read and response on port 1 with two outstanding
        applyStimulus(4'b0010, '0, '0);
        applyStimulus(4'b0010, '0, '0);
        applyStimulus(4'b0010, '0, 4'b0010);
        pushBoth("c_pend", SEL_PEND, 1, 2);
        pushBoth("c_lat", SEL_LAT, 1, 3);
        pushBoth("c_reads", SEL_RD, 1, 3);
        checkOutput();
        applyStimulus('0, '0, 4'b0010);
        applyStimulus('0, '0, 4'b0010);
        pushBoth("c_lat_end", SEL_LAT, 1, 6);
        pushBoth("c_tlat_end", SEL_TLAT, 0, 6);
        pushBoth("c_pend_end", SEL_PEND, 1, 0);
        pushBoth("c_peak", SEL_PEAK, 0, 2);
        checkOutput();
        doClear();

        // Response with nothing outstanding; flag survives clear
        applyStimulus('0, '0, 4'b1000);
        pushBoth("d_uf", SEL_UF, 0, 4'b1000);
        pushBoth("d_pend", SEL_PEND, 3, 0);
        checkOutput();
        doClear();
        pushBoth("d_uf_clear", SEL_UF, 0, 4'b1000);
        checkOutput();
        req_valid = 4'b0001;
        req_ready = 4'b0000;
        req_rw    = 4'b0000;
        rsp_valid = 4'b0010;
        rsp_ready = 4'b0000;
        tick();
        pushBoth("d_noready_rd", SEL_RD, 0, 0);
        pushBoth("d_noready_pend", SEL_PEND, 0, 0);
        pushBoth("d_noready_uf", SEL_UF, 0, 4'b1000);
        checkOutput();

        // Freeze: pending keeps tracking while counters hold
        applyStimulus(4'b0001, '0, '0);
        enable = 1'b0;
        for (int c = 0; c < 5; c++) applyStimulus(4'b0001, '0, '0);
        pushBoth("e_reads", SEL_RD, 0, 1);
        pushBoth("e_trd", SEL_TRD, 0, 1);
        pushBoth("e_lat", SEL_LAT, 0, 0);
        pushBoth("e_pend", SEL_PEND, 0, 6);
        pushBoth("e_peak", SEL_PEAK, 0, 1);
        checkOutput();
        enable = 1'b1;
        applyStimulus('0, '0, '0);
        pushBoth("e_lat_resume", SEL_LAT, 0, 6);
        pushBoth("e_peak_resume", SEL_PEAK, 0, 6);
        checkOutput();
        for (int c = 0; c < 6; c++) applyStimulus('0, '0, 4'b0001);
        pushExpect("e_lat_ovf", 0, SEL_LAT, 0, 15);
        pushExpect("e_lat_ovf", 1, SEL_LAT, 0, 11);
        pushExpect("e_tlat_ovf", 0, SEL_TLAT, 0, 15);
        pushExpect("e_tlat_ovf", 1, SEL_TLAT, 0, 11);
        pushBoth("e_pend_drain", SEL_PEND, 0, 0);
        checkOutput();
        doClear();

        // Twenty reads on a 4-bit counter, each paired with a response
        for (int c = 0; c < 20; c++) applyStimulus(4'b0001, '0, 4'b0001);
        pushExpect("f_reads", 0, SEL_RD, 0, 15);
        pushExpect("f_reads", 1, SEL_RD, 0, 4);
        pushExpect("f_trd", 0, SEL_TRD, 0, 15);
        pushExpect("f_trd", 1, SEL_TRD, 0, 4);
        pushBoth("f_pend", SEL_PEND, 0, 0);
        pushBoth("f_uf", SEL_UF, 0, 4'b1000);
        checkOutput();
        doClear();

        // Pending saturates at its maximum regardless of the counter mode
        for (int c = 0; c < 17; c++) applyStimulus(4'b0100, '0, '0);
        pushBoth("g_pend_sat", SEL_PEND, 2, 15);
        pushBoth("g_peak", SEL_PEAK, 0, 15);
        pushExpect("g_reads", 0, SEL_RD, 2, 15);
        pushExpect("g_reads", 1, SEL_RD, 2, 1);
        checkOutput();
        for (int c = 0; c < 15; c++) applyStimulus('0, '0, 4'b0100);
        pushBoth("g_pend_drain", SEL_PEND, 2, 0);
        pushBoth("g_uf_none", SEL_UF, 0, 4'b1000);
        checkOutput();
        applyStimulus('0, '0, 4'b0100);
        pushBoth("g_uf", SEL_UF, 0, 4'b1100);
        pushBoth("g_pend_floor", SEL_PEND, 2, 0);
        pushBoth("g_peak_hold", SEL_PEAK, 0, 15);
        checkOutput();

        // Reset mid-traffic: a late response to a pre-reset read flags underflow
        applyStimulus(4'b0010, '0, '0);
        reset = 1'b1;
        applyStimulus('0, '0, '0);
        reset = 1'b0;
        applyStimulus('0, '0, 4'b0010);
        pushBoth("h_uf", SEL_UF, 0, 4'b0010);
        pushBoth("h_pend", SEL_PEND, 1, 0);
        pushBoth("h_reads", SEL_RD, 1, 0);
        checkOutput();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
